// File: rtl/mem_cache_pkg.sv
// Shared types and width helpers for the MEM-stage data cache.
// Address layout: | tag | index | word offset | byte offset |
package mem_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_e;

  localparam int BYTE_OFF_W = 2;

  function automatic int off_w(input int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int aw, input int lines,
                               input int words);
    return aw - BYTE_OFF_W - off_w(words) - idx_w(lines);
  endfunction

  // Counter width that stays legal for single-word lines.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_cache_ctrl_array.sv
// Direct-mapped line storage: data words with byte enables,
// per-line tag, valid and dirty; single index, combinational read.
module cache_line_array
  import mem_cache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 26,
  parameter int IW             = 4,
  parameter int OWC            = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [OWC-1:0]   word_i,
  output logic [31:0]      rdata_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             valid_o,
  output logic             dirty_o,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic             set_dirty_i,
  input  logic             clr_dirty_i
);

  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rdata_o = data_q[idx_i][word_i];
  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          data_q[idx_i][word_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i] <= fill_tag_i;
    end
  end

  // Data and tags survive reset; only the state bits are cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end
      if (set_dirty_i) dirty_q[idx_i] <= 1'b1;
      if (clr_dirty_i) dirty_q[idx_i] <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_cache_ctrl.sv
// MEM-stage write-back, write-allocate direct-mapped data cache
// with its own miss/flush sequencer and hit/miss counters.
module mem_stage_cache_ctrl
  import mem_cache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_is_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rd_data,
  output logic              stall,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OW  = off_w(WORDS_PER_LINE);
  localparam int OWC = cnt_w(WORDS_PER_LINE);
  localparam int IW  = idx_w(NUM_LINES);
  localparam int TW  = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam logic [OWC-1:0] LAST_BEAT = OWC'(WORDS_PER_LINE - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_LINES - 1);

  state_e         state_q, state_d;
  logic [OWC-1:0] beat_q, beat_d;
  logic [IW-1:0]  scan_q, scan_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    hit_q, miss_q;

  logic [TW-1:0]  req_tag;
  logic [IW-1:0]  req_idx;
  logic [OWC-1:0] req_word;
  logic [IW-1:0]  arr_idx;
  logic [OWC-1:0] arr_word;
  logic [31:0]    arr_rdata;
  logic [TW-1:0]  arr_tag;
  logic           arr_valid, arr_dirty;
  logic           arr_we, arr_fill, arr_clr_dirty;
  logic [3:0]     arr_be;
  logic [31:0]    arr_wdata;
  logic           hit, do_access, refill_we;
  logic           count_hit, count_miss;
  logic           flushing, bursting;

  assign req_tag  = req_addr[ADDR_W-1 -: TW];
  assign req_idx  = req_addr[BYTE_OFF_W+OW +: IW];
  assign req_word = (OW == 0) ? '0 : req_addr[BYTE_OFF_W +: OWC];

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [TW-1:0]  t,
    input logic [IW-1:0]  i,
    input logic [OWC-1:0] b
  );
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(t) << (ADDR_W - TW);
    a = a | (ADDR_W'(i) << (BYTE_OFF_W + OW));
    a = a | (ADDR_W'(b) << BYTE_OFF_W);
    return a;
  endfunction

  assign flushing = (state_q == S_FLUSH_SCAN) ||
                    (state_q == S_FLUSH_WB);
  assign bursting = (state_q == S_WRITEBACK) ||
                    (state_q == S_REFILL) ||
                    (state_q == S_FLUSH_WB);
  assign arr_idx  = flushing ? scan_q : req_idx;
  assign arr_word = bursting ? beat_q : req_word;
  assign hit      = arr_valid && (arr_tag == req_tag);

  assign arr_we    = refill_we || (do_access && req_write);
  assign arr_be    = (refill_we || req_is_word) ? 4'hF
                   : 4'b0001 << req_addr[1:0];
  assign arr_wdata = refill_we   ? mem_rdata
                   : req_is_word ? req_wdata
                   : {4{req_wdata[7:0]}};

  cache_line_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TW),
    .IW             (IW),
    .OWC            (OWC)
  ) u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .idx_i       (arr_idx),
    .word_i      (arr_word),
    .rdata_o     (arr_rdata),
    .tag_o       (arr_tag),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .we_i        (arr_we),
    .be_i        (arr_be),
    .wdata_i     (arr_wdata),
    .fill_i      (arr_fill),
    .fill_tag_i  (req_tag),
    .set_dirty_i (do_access && req_write),
    .clr_dirty_i (arr_clr_dirty)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    scan_d        = scan_q;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    stall         = 1'b1;
    flush_done    = 1'b0;
    do_access     = 1'b0;
    count_hit     = 1'b0;
    count_miss    = 1'b0;
    refill_we     = 1'b0;
    arr_fill      = 1'b0;
    arr_clr_dirty = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = 1'b0;
        if (flush_req) begin
          stall   = 1'b1;
          scan_d  = '0;
          state_d = S_FLUSH_SCAN;
        end else if (req_valid && hit) begin
          do_access = 1'b1;
          count_hit = 1'b1;
        end else if (req_valid) begin
          stall      = 1'b1;
          count_miss = 1'b1;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = arr_valid && arr_dirty;
          state_d    = mem_we_d ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + OWC'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            mem_we_d = 1'b0;
            state_d  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          refill_we = 1'b1;
          beat_d    = beat_q + OWC'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            mem_req_d = 1'b0;
            arr_fill  = 1'b1;
            state_d   = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        stall     = 1'b0;
        do_access = req_valid;
        state_d   = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (arr_valid && arr_dirty) begin
          beat_d    = '0;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          state_d   = S_FLUSH_WB;
        end else if (scan_q == LAST_IDX) begin
          flush_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          scan_d = scan_q + IW'(1);
        end
      end
      S_FLUSH_WB: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + OWC'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d        = '0;
            mem_req_d     = 1'b0;
            mem_we_d      = 1'b0;
            arr_clr_dirty = 1'b1;
            state_d       = S_FLUSH_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      scan_q    <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      scan_q    <= scan_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (count_hit && hit_q != '1) hit_q <= hit_q + 32'd1;
      if (count_miss && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  // Beat address comes from the live beat counter, so it stays
  // stable for as long as the registered request is held.
  always_comb begin
    mem_addr = '0;
    if (mem_req_q) begin
      mem_addr = beat_addr((state_q == S_REFILL) ? req_tag : arr_tag,
                           arr_idx, beat_q);
    end
  end

  always_comb begin
    rd_data = '0;
    if (do_access) begin
      rd_data = req_is_word ? arr_rdata
              : {24'h0, arr_rdata[8*req_addr[1:0] +: 8]};
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_we_q ? arr_rdata : 32'h0;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_mem_stage_cache_ctrl.sv
// Directed + randomized bench for mem_stage_cache_ctrl against a
// flat-memory reference and a line-presence model.
module tb_mem_stage_cache_ctrl;

  localparam int NL  = 16;
  localparam int WPL = 4;
  localparam int LB  = 4 * WPL;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_is_word;
  logic [31:0] req_addr, req_wdata, rd_data;
  logic        stall, flush_req, flush_done;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  mem_stage_cache_ctrl #(
    .NUM_LINES(NL), .WORDS_PER_LINE(WPL), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_is_word(req_is_word), .req_addr(req_addr),
    .req_wdata(req_wdata), .rd_data(rd_data),
    .stall(stall), .flush_req(flush_req),
    .flush_done(flush_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       beats[$];
  beat_t       exp_q[$];
  logic [31:0] ext_mem [logic [31:0]];
  logic [31:0] gold    [logic [31:0]];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [31:0] m_tag   [NL];
  int          exp_hits, exp_misses;
  int          checks, failures;
  int          mem_wait, wait_cnt, hold_viol;
  logic        prev_pend;
  logic [31:0] prev_addr;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'(LB)) % 32'(NL));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'(LB * NL);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] t,
                                            input int i);
    return (t * 32'(NL) + 32'(i)) * 32'(LB);
  endfunction

  // Memory: accepts a beat after mem_wait idle cycles of request.
  always @(posedge clk) begin
    beat_t b;
    if (prev_pend && (!mem_req || mem_addr !== prev_addr))
      hold_viol++;
    prev_pend = mem_req && !mem_ready && !rst;
    prev_addr = mem_addr;
    if (mem_req && mem_ready) begin
      b.we   = mem_we;
      b.addr = mem_addr;
      b.data = mem_we ? mem_wdata : 32'h0;
      beats.push_back(b);
      if (mem_we) ext_mem[mem_addr] = mem_wdata;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    #2;
    mem_ready = mem_req && (wait_cnt >= mem_wait);
    mem_rdata = (mem_req && !mem_we) ? ext_rd(mem_addr) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    beat_t b;
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        for (int w = 0; w < WPL; w++) begin
          b.we   = 1'b1;
          b.addr = line_base(m_tag[i], i) + 32'(4 * w);
          b.data = gold_rd(b.addr);
          exp_q.push_back(b);
        end
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  task automatic model_access(input bit wr, input bit word,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              output logic [31:0] exp_rd,
                              output int exp_stall);
    beat_t       b;
    int          i;
    logic [31:0] t, wa, old;
    int          sh;
    i  = idx_of(a);
    t  = tag_of(a);
    wa = a & ~32'h3;
    sh = 8 * int'(a[1:0]);
    exp_stall = 0;
    if (m_valid[i] && m_tag[i] == t) begin
      exp_hits++;
    end else begin
      exp_misses++;
      exp_stall = 1 + WPL * (mem_wait + 1);
      if (m_valid[i] && m_dirty[i]) begin
        exp_stall += WPL * (mem_wait + 1);
        for (int w = 0; w < WPL; w++) begin
          b.we   = 1'b1;
          b.addr = line_base(m_tag[i], i) + 32'(4 * w);
          b.data = gold_rd(b.addr);
          exp_q.push_back(b);
        end
      end
      for (int w = 0; w < WPL; w++) begin
        b.we   = 1'b0;
        b.addr = line_base(t, i) + 32'(4 * w);
        b.data = 32'h0;
        exp_q.push_back(b);
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_dirty[i] = 1'b0;
    end
    old    = gold_rd(wa);
    exp_rd = word ? old : ((old >> sh) & 32'hFF);
    if (wr) begin
      gold[wa] = word ? wd
               : (old & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
      m_dirty[i] = 1'b1;
    end
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "/nbeats"}, 32'(beats.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < beats.size()) begin
        chk({tag, "/baddr"}, beats[k].addr, exp_q[k].addr);
        chk({tag, "/bwe"}, 32'(beats[k].we), 32'(exp_q[k].we));
        if (exp_q[k].we)
          chk({tag, "/bdata"}, beats[k].data, exp_q[k].data);
      end
    end
  endtask

  task automatic run_access(input bit wr, input bit word,
                            input logic [31:0] a,
                            input logic [31:0] wd,
                            input bit with_flush, input string tag);
    logic [31:0] exp_rd, got_rd;
    int          exp_stall, st, fd;
    bit          tmo;
    exp_q.delete();
    if (with_flush) model_flush();
    model_access(wr, word, a, wd, exp_rd, exp_stall);
    @(posedge clk); #1;
    beats.delete();
    req_valid   = 1'b1;
    req_write   = wr;
    req_is_word = word;
    req_addr    = a;
    req_wdata   = wd;
    flush_req   = with_flush;
    st = 0; fd = 0; tmo = 1'b0;
    forever begin
      @(negedge clk);
      if (flush_done) fd++;
      if (!stall) break;
      st++;
      if (st > 600) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
      flush_req = 1'b0;
    end
    got_rd = rd_data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush_req = 1'b0;
    @(negedge clk);
    chk({tag, "/timeout"}, 32'(tmo), 32'd0);
    if (with_flush) chk({tag, "/flush_done"}, fd, 1);
    else chk({tag, "/stall_cycles"}, st, exp_stall);
    if (!wr) chk({tag, "/rd_data"}, got_rd, exp_rd);
    chk_beats(tag);
    chk({tag, "/hit_count"}, hit_count, exp_hits);
    chk({tag, "/miss_count"}, miss_count, exp_misses);
  endtask

  task automatic run_flush(input string tag);
    int n, fd;
    exp_q.delete();
    model_flush();
    @(posedge clk); #1;
    beats.delete();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 0; fd = 0;
    while (fd == 0 && n < 600) begin
      @(negedge clk);
      if (flush_done) fd++;
      n++;
    end
    chk({tag, "/done_seen"}, fd, 1);
    @(negedge clk);
    chk({tag, "/done_pulse"}, 32'(flush_done), 32'd0);
    chk({tag, "/stall_after"}, 32'(stall), 32'd0);
    chk_beats(tag);
  endtask

  initial begin
    logic [31:0] a, d;
    int          ns;
    checks = 0; failures = 0;
    exp_hits = 0; exp_misses = 0;
    mem_wait = 0; wait_cnt = 0; hold_viol = 0;
    prev_pend = 1'b0; prev_addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_is_word = 1'b1; req_addr = '0; req_wdata = '0;
    flush_req = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    ext_mem[32'h40] = 32'h1122_3344;
    gold[32'h40]    = 32'h1122_3344;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst/stall", 32'(stall), 32'd0);
    chk("rst/mem_req", 32'(mem_req), 32'd0);
    chk("rst/mem_we", 32'(mem_we), 32'd0);
    chk("rst/flush_done", 32'(flush_done), 32'd0);
    chk("rst/hit_count", hit_count, 32'd0);
    chk("rst/miss_count", miss_count, 32'd0);
    chk("rst/rd_data", rd_data, 32'd0);

    run_access(0, 1, 32'h40, 0, 0, "cold_load");
    run_access(0, 1, 32'h40, 0, 0, "hit_load");
    run_access(1, 0, 32'h41, 32'hAB, 0, "byte_store");
    run_access(0, 1, 32'h40, 0, 0, "word_after_byte");
    run_access(0, 0, 32'h43, 0, 0, "byte_load_lane3");
    run_access(1, 1, 32'h40, 32'hCAFE_F00D, 0, "word_store");
    run_access(0, 1, 32'h440, 0, 0, "dirty_evict");

    mem_wait  = 3;
    hold_viol = 0;
    run_access(0, 1, 32'h884, 0, 0, "slow_mem");
    chk("slow_mem/hold", hold_viol, 0);
    mem_wait = 0;

    run_access(1, 1, 32'h10, 32'h0BAD_BEEF, 0, "dirty_a");
    run_access(1, 0, 32'h26, 32'h5C, 0, "dirty_b");
    run_access(0, 1, 32'h44C, 0, 1, "flush_with_req");
    run_flush("flush_clean");

    // Abort a refill in flight with reset.
    mem_wait = 2;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_is_word = 1'b1;
    req_addr = 32'h200;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst/stall", 32'(stall), 32'd0);
    chk("midrst/mem_req", 32'(mem_req), 32'd0);
    chk("midrst/hit_count", hit_count, 32'd0);
    chk("midrst/miss_count", miss_count, 32'd0);
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
    exp_hits = 0; exp_misses = 0;
    mem_wait = 0;
    run_access(0, 1, 32'h200, 0, 0, "after_rst");

    for (int n = 0; n < 150; n++) begin
      mem_wait = $urandom_range(0, 2);
      a  = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 255));
      d  = $urandom;
      ns = $urandom_range(0, 1);
      if (ns == 1) a = a & ~32'h3;
      run_access($urandom_range(0, 9) < 4, ns == 1, a, d,
                 $urandom_range(0, 29) == 0, "rand");
    end

    mem_wait = 0;
    run_flush("final_flush");
    foreach (gold[k]) chk("final_mem", ext_rd(k), gold[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
